// File: rtl/puf_rng_pkg.sv
// Shared types and defaults for the PUF RNG nibble collector.
package puf_rng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HALT = 2'd2
  } rng_col_state_e;

  localparam int NibW            = 4;
  localparam int DefWordWidth    = 32;
  localparam int DefFifoDepth    = 4;
  localparam int DefRepCntThresh = 8;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous word FIFO with optional pass-through when empty.
module prim_fifo_sync #(
  parameter int Width  = 32,
  parameter int Depth  = 4,
  parameter bit Pass   = 1'b0,
  parameter int DepthW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic [DepthW-1:0] depth_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0]   PtrLast  = PtrW'(Depth - 1);
  localparam logic [DepthW-1:0] DepthMax = DepthW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr, rptr;
  logic             empty, full, bypass, wr_en, rd_en;

  assign empty    = (depth_o == '0);
  assign full     = (depth_o == DepthMax);
  assign bypass   = Pass & empty;
  assign wready_o = ~full;
  assign rvalid_o = ~empty | (bypass & wvalid_i);
  assign rdata_o  = bypass ? wdata_i : mem[rptr];
  // A bypassed word consumed in the same cycle never enters storage.
  assign wr_en    = wvalid_i & ~full & ~(bypass & rready_i);
  assign rd_en    = rready_i & ~empty;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr    <= '0;
      rptr    <= '0;
      depth_o <= '0;
    end else begin
      if (wr_en) wptr <= (wptr == PtrLast) ? '0 : wptr + 1'b1;
      if (rd_en) rptr <= (rptr == PtrLast) ? '0 : rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   depth_o <= depth_o + 1'b1;
        2'b01:   depth_o <= depth_o - 1'b1;
        default: depth_o <= depth_o;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr] <= wdata_i;
  end

endmodule

// File: rtl/puf_rng_collector.sv
// Collects PUF RNG nibbles, runs a repetition-count health test, packs
// nibbles into words and buffers them for a valid/ready entropy consumer.
module puf_rng_collector
  import puf_rng_pkg::*;
#(
  parameter int WordWidth    = DefWordWidth,
  parameter int FifoDepth    = DefFifoDepth,
  parameter int RepCntThresh = DefRepCntThresh
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           enable_i,
  input  logic                           rng_mode_i,
  input  logic [NibW-1:0]                rng4bit_i,
  input  logic                           rng4bit_done_i,
  output logic                           es_rng_req_o,
  output logic                           word_valid_o,
  input  logic                           word_ready_i,
  output logic [WordWidth-1:0]           word_o,
  output logic [$clog2(FifoDepth+1)-1:0] fifo_depth_o,
  output logic                           health_fail_o,
  input  logic                           health_clr_i
);

  localparam int NibPerWord = WordWidth / NibW;
  localparam int NibCntW    = (NibPerWord > 1) ? $clog2(NibPerWord) : 1;
  localparam int RepCntW    = $clog2(RepCntThresh + 1);
  localparam int DepthW     = $clog2(FifoDepth + 1);
  localparam logic [NibCntW-1:0] LastNib     = NibCntW'(NibPerWord - 1);
  localparam logic [RepCntW-1:0] RepMax      = RepCntW'(RepCntThresh);
  localparam logic [DepthW-1:0]  DepthFull   = DepthW'(FifoDepth);
  localparam logic [DepthW-1:0]  DepthAlmost = DepthW'(FifoDepth - 1);

  rng_col_state_e       state;
  logic [NibCntW-1:0]   nib_cnt;
  logic [RepCntW-1:0]   rep_cnt, rep_next;
  logic [NibW-1:0]      prev_nib;
  logic [WordWidth-1:0] word_buf, word_next, fifo_rdata;
  logic                 nib_acc, health_trip, push, pop, fifo_wready, can_start;

  // A nibble counts only while requesting and not being disabled this cycle.
  assign nib_acc     = es_rng_req_o & rng4bit_done_i & enable_i & rng_mode_i;
  assign health_trip = nib_acc & (rep_next == RepMax);
  assign push        = nib_acc & ~health_trip & (nib_cnt == LastNib);
  assign pop         = word_valid_o & word_ready_i;
  assign can_start   = enable_i & rng_mode_i & ~health_fail_o & (fifo_depth_o < DepthFull);
  assign word_o      = word_valid_o ? fifo_rdata : '0;

  // Run length of the incoming nibble, counting from 1 after IDLE/reset.
  always_comb begin
    rep_next = RepCntW'(1);
    if (rep_cnt != '0 && rng4bit_i == prev_nib)
      rep_next = (rep_cnt == RepMax) ? RepMax : rep_cnt + 1'b1;
  end

  // Current word with the incoming nibble dropped into its slot.
  always_comb begin
    word_next = word_buf;
    word_next[NibW*nib_cnt +: NibW] = rng4bit_i;
  end

  // Nibble assembly register.
  always_ff @(posedge clk_i) begin
    if (nib_acc) word_buf <= word_next;
  end

  // Control FSM with nibble count, health state and registered request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      es_rng_req_o  <= 1'b0;
      health_fail_o <= 1'b0;
      nib_cnt       <= '0;
      rep_cnt       <= '0;
      prev_nib      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (can_start) begin
            state        <= REQ;
            es_rng_req_o <= 1'b1;
          end
        end
        REQ: begin
          if (!enable_i || !rng_mode_i) begin
            state        <= IDLE;
            es_rng_req_o <= 1'b0;
            nib_cnt      <= '0;
            rep_cnt      <= '0;
          end else if (health_trip) begin
            state         <= HALT;
            es_rng_req_o  <= 1'b0;
            health_fail_o <= 1'b1;
            nib_cnt       <= '0;
            rep_cnt       <= rep_next;
          end else if (nib_acc) begin
            prev_nib <= rng4bit_i;
            rep_cnt  <= rep_next;
            if (push) begin
              nib_cnt <= '0;
              // Stop before the FIFO can overflow; resume from IDLE once drained.
              if (fifo_depth_o >= DepthAlmost) begin
                state        <= IDLE;
                es_rng_req_o <= 1'b0;
                rep_cnt      <= '0;
              end
            end else begin
              nib_cnt <= nib_cnt + 1'b1;
            end
          end
        end
        HALT: begin
          if (health_clr_i) begin
            state         <= IDLE;
            health_fail_o <= 1'b0;
            rep_cnt       <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          es_rng_req_o <= 1'b0;
        end
      endcase
    end
  end

  prim_fifo_sync #(
    .Width (WordWidth),
    .Depth (FifoDepth),
    .Pass  (1'b0)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wvalid_i (push),
    .wready_o (fifo_wready),
    .wdata_i  (word_next),
    .rvalid_o (word_valid_o),
    .rready_i (word_ready_i),
    .rdata_o  (fifo_rdata),
    .depth_o  (fifo_depth_o)
  );

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> fifo_wready);
  a_halt_no_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state == HALT) |-> !es_rng_req_o);
  a_word_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (word_valid_o && !word_ready_i) |=> $stable(word_o));

endmodule
